// File: rtl/lsu.sv
// Load/store unit: one access per instruction from ex, stalls the pipe,
// drives a req/gnt/rvalid bus with byte lanes and extends load data.
module lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [4:0]        rd_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              rd_we_o,
  output logic [4:0]        rd_waddr_o,
  output logic [DATA_W-1:0] rd_wdata_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [4:0]        rd_q, rd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              is_b, is_h, is_w;
  logic              legal, aligned, ok;
  logic [1:0]        off;
  logic [3:0]        be_new;
  logic [DATA_W-1:0] wdata_new;

  always_comb begin
    is_b = funct3_i[1:0] == 2'd0;
    is_h = funct3_i[1:0] == 2'd1;
    is_w = funct3_i[1:0] == 2'd2;
    off  = addr_i[1:0];
    if (we_i) begin
      legal = ~funct3_i[2] & ~(&funct3_i[1:0]);
    end else begin
      legal = ~(&funct3_i[1:0]) & ~(funct3_i[2] & funct3_i[1]);
    end
    aligned   = 1'b1;
    be_new    = 4'hF;
    wdata_new = wdata_i;
    unique case (1'b1)
      is_b: begin
        be_new    = 4'b0001 << off;
        wdata_new = {4{wdata_i[7:0]}};
      end
      is_h: begin
        aligned   = ~addr_i[0];
        be_new    = 4'b0011 << off;
        wdata_new = {2{wdata_i[15:0]}};
      end
      is_w: begin
        aligned = addr_i[1:0] == 2'b00;
      end
      default: begin
        aligned = 1'b1;
      end
    endcase
    ok = legal & aligned;
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i && ok) begin
          state_d = REQ;
          we_d    = we_i;
          f3_d    = funct3_i;
          addr_d  = addr_i;
          be_d    = be_new;
          wdata_d = wdata_i;
          wdata_d = wdata_new;
          rd_d    = rd_addr_i;
        end else if (req_i) begin
          err_d = 1'b1;
        end
      end
      REQ: begin
        if (bus_gnt_i) state_d = RESP;
      end
      RESP: begin
        if (bus_rvalid_i) begin
          state_d = DONE;
          rdata_d = bus_rdata_i;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  logic              in_bus;
  logic              in_done;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_ext;

  always_comb begin
    unique case (addr_q[1:0])
      2'd0:    ld_byte = rdata_q[7:0];
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    unique case (f3_q)
      3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_ext = {24'd0, ld_byte};
      3'd5:    ld_ext = {16'd0, ld_half};
      default: ld_ext = rdata_q;
    endcase
  end

  // bus fields are only driven while the access owns the bus
  assign in_bus      = (state_q == REQ) | (state_q == RESP);
  assign in_done     = state_q == DONE;
  assign busy_o      = in_bus | ((state_q == IDLE) & req_i & ok);
  assign done_o      = in_done;
  assign err_o       = err_q;
  assign rd_we_o     = in_done & ~we_q;
  assign rd_waddr_o  = in_done ? rd_q : 5'd0;
  assign rd_wdata_o  = (in_done & ~we_q) ? ld_ext : '0;
  assign bus_req_o   = state_q == REQ;
  assign bus_we_o    = in_bus & we_q;
  assign bus_addr_o  = in_bus ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus_be_o    = in_bus ? be_q : 4'h0;
  assign bus_wdata_o = in_bus ? wdata_q : '0;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the execute stage. It accepts one memory access per instruction from `ex`, stalls the pipeline while it runs, and drives a request/grant/response data bus with byte enables, replacing read-modify-write for sub-word stores. For loads it returns the sign- or zero-extended result and a register-write strobe.

## Interface
Parameters:
- `ADDR_W`, 32, bus and access address width
- `DATA_W`, 32, data width (fixed at 32; 4 byte lanes)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_i`  in  1  access request from ex; held while `busy_o`
- `we_i`  in  1  1 = store, 0 = load
- `funct3_i`  in  3  RV32I load/store funct3
- `addr_i`  in  32  effective byte address (rs1 + imm)
- `wdata_i`  in  32  raw rs2 value
- `rd_addr_i`  in  5  load destination register
- `busy_o`  out  1  hold request to pipeline control
- `done_o`  out  1  one-cycle completion pulse
- `err_o`  out  1  one-cycle misaligned/illegal pulse
- `rd_we_o`  out  1  register write strobe (loads only, with `done_o`)
- `rd_waddr_o`  out  5  destination register
- `rd_wdata_o`  out  32  extended load data
- `bus_req_o`  out  1  bus request
- `bus_we_o`  out  1  bus write
- `bus_addr_o`  out  32  word-aligned address (`[1:0]`=0)
- `bus_be_o`  out  4  byte enables
- `bus_wdata_o`  out  32  lane-replicated store data
- `bus_gnt_i`  in  1  request accepted
- `bus_rvalid_i`  in  1  response (read data or write ack)
- `bus_rdata_i`  in  32  read data

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE: on `req_i`, decode. Legal + aligned: capture we, funct3, addr, lane-formatted wdata, be, rd_addr; go REQ. Otherwise pulse `err_o` next cycle, stay IDLE, no bus activity.
- Misaligned: LH/LHU/SH with `addr[0]`=1; LW/SW with `addr[1:0]`≠0. Illegal: load funct3 3,6,7; store funct3 ≥3.
- REQ: `bus_req_o`=1, all bus outputs stable from capture; on `bus_gnt_i` go RESP.
- RESP: `bus_req_o`=0; on `bus_rvalid_i` capture `bus_rdata_i`, go DONE.
- DONE: `done_o`=1; loads also `rd_we_o`=1 with `rd_wdata_o` valid; go IDLE unconditionally. `req_i` ignored in DONE.
- Store lanes (off = `addr[1:0]`): SB be=`4'b0001<<off`, wdata={4{rs2[7:0]}}; SH be=`4'b0011<<off`, wdata={2{rs2[15:0]}}; SW be=`4'hF`, wdata=rs2.
- Load extract: byte = rdata[off*8+:8]; half = rdata[off*8+:16]; LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough.
- Loads drive be per same lane rule (informational).
- `busy_o` = (state∈{REQ,RESP}) | (state==IDLE & `req_i` & legal & aligned); combinational so ex holds the same cycle a request appears.
- `bus_rvalid_i` in IDLE/REQ/DONE ignored (stale responses after reset).

## Timing
- Reset: state=IDLE; every output 0 (`bus_addr_o`, `bus_be_o`, `bus_wdata_o`, `rd_wdata_o`, `rd_waddr_o` = 0).
- Reset mid-transaction: next cycle IDLE, bus outputs 0, no `done_o`; late `bus_rvalid_i` ignored.
- Minimum latency with `bus_gnt_i` first REQ cycle and `bus_rvalid_i` first RESP cycle: accept at cycle 0, REQ 1, RESP 2, `done_o` at cycle 3; `busy_o` high cycles 0-2, low at 3.
- Each gnt wait cycle and each rvalid wait cycle adds one cycle.
- `bus_rvalid_i` is never expected in the same cycle as `bus_gnt_i`; only RESP samples it.
- `err_o` asserted the cycle after the offending request, `busy_o` stays 0.
- Back-to-back: new request accepted earliest the cycle after DONE (4-cycle minimum spacing).
- `rd_we_o`/`rd_wdata_o` valid only during `done_o`; `rd_we_o` 0 for stores and on error.

## Test plan
- LW addr 0x100, gnt/rvalid immediate, rdata 0xDEADBEEF -> bus_addr 0x100, be 0xF; cycle 3 done_o=1, rd_we_o=1, rd_wdata_o=0xDEADBEEF; busy_o high cycles 0-2.
- LB addr 0x103, rdata 0x80FF_0000 -> be 0x8, rd_wdata_o 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
- SB addr 0x201, rs2 0x123456AB -> bus_addr 0x200, be 0x2, bus_wdata 0xABABABAB, bus_we 1; done_o with rd_we_o=0.
- SH addr 0x202 with gnt delayed 3 cycles, rvalid delayed 2 -> bus outputs stable throughout, be 0xC, done_o at cycle 8.
- LW addr 0x102 and SH addr 0x301 -> err_o pulse next cycle, bus_req_o never asserted, busy_o 0.
- rst during RESP, then rvalid arrives -> all outputs 0, no done_o, following LW completes normally.
